// File: rtl/eka_dmem_if.sv
// eka_dmem_if
//   Bundles the Eka core data-port signals between the core (master) and the
//   data-memory responder (slave).
//
//   data_addr    core -> mem  byte address
//   mem_wr_data  core -> mem  lane-replicated write data
//   mem_wr_mask  core -> mem  byte-lane write enables (bit i = bits 8i+7:8i)
//   mem_wr       core -> mem  write request
//   mem_rd       core -> mem  read request
//   mem_rd_data  mem -> core  full read word
//   data_stall   mem -> core  high while an accepted request is incomplete
interface eka_dmem_if;
    logic [31:0] data_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_wr_mask;
    logic        mem_wr;
    logic        mem_rd;
    logic [31:0] mem_rd_data;
    logic        data_stall;

    modport master (
        output data_addr, mem_wr_data, mem_wr_mask, mem_wr, mem_rd,
        input  mem_rd_data, data_stall
    );

    modport slave (
        input  data_addr, mem_wr_data, mem_wr_mask, mem_wr, mem_rd,
        output mem_rd_data, data_stall
    );
endinterface

// File: rtl/eka_dmem_responder.sv
// eka_dmem_responder
//   Memory-side end of the Eka core data port. Holds a byte-laned word memory
//   with a configurable access latency. A request seen while idle is
//   registered, data_stall is held until the access commits, and the read
//   word is then presented for one non-stalled (DONE) cycle.
//
//   Parameters
//     DEPTH_WORDS  number of 32-bit words (power of two)
//     LATENCY      extra wait cycles before commit (0..15)
//   Ports
//     clk          rising-edge clock
//     reset        synchronous, active-high
//     bus          eka_dmem_if.slave (address, write data/mask, rd/wr
//                  requests in; read data and stall out)
module eka_dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    eka_dmem_if.slave   bus
);
    localparam int IW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        stall_c;
    logic        req_present;
    logic        accept;
    logic        commit;

    // Registered request; only consulted at commit, so no reset needed.
    logic [IW-1:0] req_idx;
    logic [31:0]   req_wdata;
    logic [3:0]    req_mask;
    logic          req_wr;
    logic          req_rd;

    logic [31:0]   rd_data_q;
    logic [31:0]   mem [DEPTH_WORDS];

    // Byte-offset bits and bits above the word index are don't-care; the
    // upper bits being ignored is what makes addresses alias.
    logic unused_addr;
    assign unused_addr = ^{bus.data_addr[31:IW+2], bus.data_addr[1:0]};

    assign req_present = bus.mem_rd | bus.mem_wr;
    assign accept      = (state == ST_IDLE) && req_present;
    assign commit      = (state == ST_WAIT) && (cnt == 4'd0);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_c   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                stall_c = req_present;
                if (req_present) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = 4'(LATENCY);
                end
            end
            ST_WAIT: begin
                stall_c = 1'b1;
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // The request still shown by the core here is the one being
                // retired, so it is not re-accepted.
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.data_stall  = reset ? 1'b0 : stall_c;
    assign bus.mem_rd_data = rd_data_q;

    // Control state; reset wins over commit, aborting any request in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            rd_data_q <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            // Non-blocking read returns the pre-write word on a rd+wr commit.
            if (commit && req_rd) begin
                rd_data_q <= mem[req_idx];
            end
        end
    end

    // Request capture at the IDLE acceptance edge only.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_idx   <= bus.data_addr[IW+1:2];
            req_wdata <= bus.mem_wr_data;
            req_mask  <= bus.mem_wr_mask;
            req_wr    <= bus.mem_wr;
            req_rd    <= bus.mem_rd;
        end
    end

    // Byte-laned memory write; contents survive reset.
    always_ff @(posedge clk) begin
        if (!reset && commit && req_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (req_mask[i]) begin
                    mem[req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_eka_dmem_responder.sv
// tb_eka_dmem_responder
//   Drives two responders (LATENCY=2 and LATENCY=0, both 1024 words) through
//   directed accesses. Expected read words come from a bench memory model and
//   are queued at issue time, then popped in the DONE cycle.
module tb_eka_dmem_responder;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    eka_dmem_if bus_l2 ();
    eka_dmem_if bus_l0 ();

    eka_dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut_l2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_l2.slave)
    );

    eka_dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dut_l0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_l0.slave)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] sb_q [$];
    logic [31:0] model [2][1024];
    logic [31:0] last_rd [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int w, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] mask, input logic wr, input logic rd);
        if (w == 0) begin
            bus_l2.data_addr   = addr;
            bus_l2.mem_wr_data = data;
            bus_l2.mem_wr_mask = mask;
            bus_l2.mem_wr      = wr;
            bus_l2.mem_rd      = rd;
        end else begin
            bus_l0.data_addr   = addr;
            bus_l0.mem_wr_data = data;
            bus_l0.mem_wr_mask = mask;
            bus_l0.mem_wr      = wr;
            bus_l0.mem_rd      = rd;
        end
    endtask

    function automatic logic get_stall(input int w);
        return (w == 0) ? bus_l2.data_stall : bus_l0.data_stall;
    endfunction

    function automatic logic [31:0] get_rd(input int w);
        return (w == 0) ? bus_l2.mem_rd_data : bus_l0.mem_rd_data;
    endfunction

    // Called just after a rising edge with the DUT idle. Returns just after
    // the rising edge that ends the DONE cycle.
    task automatic access(input int w, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] mask, input logic wr, input logic rd,
                          input int exp_stall, input string tag);
        int          n;
        int          idx;
        logic [31:0] exp;
        idx = int'(addr[11:2]);
        set_req(w, addr, data, mask, wr, rd);
        if (rd) sb_q.push_back(model[w][idx]);
        if (wr) begin
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) model[w][idx][8*i +: 8] = data[8*i +: 8];
            end
        end
        n = 0;
        @(negedge clk);
        while (get_stall(w) === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check({tag, " stall cycles"}, 32'(n), 32'(exp_stall));
        if (rd) begin
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hx;
            last_rd[w] = exp;
        end else begin
            exp = last_rd[w];
        end
        check({tag, " rd_data"}, get_rd(w), exp);
        set_req(w, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        set_req(0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
        set_req(1, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Quiet period after reset.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("idle stall l2", 32'(get_stall(0)), 32'd0);
            check("idle rd_data l2", get_rd(0), 32'd0);
            check("idle stall l0", 32'(get_stall(1)), 32'd0);
            check("idle rd_data l0", get_rd(1), 32'd0);
        end
        @(posedge clk);
        #1;

        // LATENCY=2: full-word write then read.
        access(0, 32'h40, 32'hDEADBEEF, 4'b1111, 1'b1, 1'b0, 4, "l2 wr 0x40");
        access(0, 32'h40, 32'h0,        4'b0000, 1'b0, 1'b1, 4, "l2 rd 0x40");

        // Byte-lane masks; low address bits ignored.
        access(0, 32'h41, 32'h11111111, 4'b0010, 1'b1, 1'b0, 4, "l2 wr mask0010");
        access(0, 32'h40, 32'h0,        4'b0000, 1'b0, 1'b1, 4, "l2 rd after mask0010");
        check("mask0010 value", last_rd[0], 32'hDEAD11EF);
        access(0, 32'h42, 32'h22222222, 4'b1100, 1'b1, 1'b0, 4, "l2 wr mask1100");
        access(0, 32'h40, 32'h0,        4'b0000, 1'b0, 1'b1, 4, "l2 rd after mask1100");
        check("mask1100 value", last_rd[0], 32'h222211EF);

        // Zero mask write: full latency, no change.
        access(0, 32'h40, 32'hFFFFFFFF, 4'b0000, 1'b1, 1'b0, 4, "l2 wr mask0000");
        access(0, 32'h40, 32'h0,        4'b0000, 1'b0, 1'b1, 4, "l2 rd after mask0000");

        // Simultaneous read and write returns the old word.
        access(0, 32'h80, 32'h5, 4'b1111, 1'b1, 1'b0, 4, "l2 wr 0x80 old");
        access(0, 32'h80, 32'h9, 4'b1111, 1'b1, 1'b1, 4, "l2 rdwr 0x80");
        check("rdwr pre-write value", last_rd[0], 32'h5);
        access(0, 32'h80, 32'h0, 4'b0000, 1'b0, 1'b1, 4, "l2 rd 0x80 new");
        check("rdwr post-write value", last_rd[0], 32'h9);

        // Reset during the second WAIT cycle aborts the write.
        access(0, 32'h10, 32'h12345678, 4'b1111, 1'b1, 1'b0, 4, "l2 wr 0x10 prior");
        set_req(0, 32'h10, 32'hFFFFFFFF, 4'b1111, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("abort stall forced low", 32'(get_stall(0)), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_req(0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("abort back to idle", 32'(get_stall(0)), 32'd0);
        check("abort rd_data cleared", get_rd(0), 32'd0);
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        @(posedge clk);
        #1;
        access(0, 32'h10, 32'h0, 4'b0000, 1'b0, 1'b1, 4, "l2 rd 0x10 after abort");
        check("abort kept prior", last_rd[0], 32'h12345678);

        // Address wrap at DEPTH_WORDS*4 bytes.
        access(0, 32'h1000, 32'hA5A5A5A5, 4'b1111, 1'b1, 1'b0, 4, "l2 wr 0x1000");
        access(0, 32'h0,    32'h0,        4'b0000, 1'b0, 1'b1, 4, "l2 rd 0x0 wrap");
        check("wrap value", last_rd[0], 32'hA5A5A5A5);

        // LATENCY=0 instance.
        access(1, 32'h20, 32'hCAFEF00D, 4'b1111, 1'b1, 1'b0, 2, "l0 wr 0x20");
        access(1, 32'h20, 32'h0,        4'b0000, 1'b0, 1'b1, 2, "l0 rd 0x20");
        access(1, 32'h20, 32'h01020304, 4'b0101, 1'b1, 1'b1, 2, "l0 rdwr 0x20");
        access(1, 32'h20, 32'h0,        4'b0000, 1'b0, 1'b1, 2, "l0 rd 0x20 merged");
        check("l0 merged value", last_rd[1], 32'hCA02F004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
